// File: rtl/dwt97_pkg.sv
// Shared types and helpers for the 9/7 DWT front end: pair-packer state and
// the JPEG2000 DC level shift into DWT fixed point.
package dwt97_pkg;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } pack_state_t;

    localparam int PIXEL_WIDTH = 8;
    localparam int DATA_WIDTH  = 16;
    localparam int IN_SHIFT    = 4;
    localparam int DC_OFFSET   = 1 << (PIXEL_WIDTH - 1);

    // Centre an unsigned pixel on zero, then scale it into the DWT fixed point.
    function automatic int level_shift(input int pix,
                                       input int offset   = DC_OFFSET,
                                       input int in_shift = IN_SHIFT);
        return (pix - offset) <<< in_shift;
    endfunction

endpackage

// File: rtl/pixel_pair_packer.sv
// Level-shifts a raster pixel stream and packs it into {odd, even} sample pairs
// for the DWT, padding odd-length rows by symmetric extension.
module pixel_pair_packer
    import dwt97_pkg::*;
#(
    parameter int PixelWidth = PIXEL_WIDTH,
    parameter int DataWidth  = DATA_WIDTH,
    parameter int InShift    = IN_SHIFT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   s_ready_o,
    input  logic                   s_valid_i,
    input  logic                   s_sof_i,
    input  logic                   s_eol_i,
    input  logic [PixelWidth-1:0]  s_data_i,
    input  logic                   m_ready_i,
    output logic                   m_valid_o,
    output logic                   m_sof_o,
    output logic                   m_eol_o,
    output logic [2*DataWidth-1:0] m_data_o
);

    if (PixelWidth + InShift > DataWidth) begin : g_width_check
        $error("pixel_pair_packer: PixelWidth + InShift exceeds DataWidth");
    end

    localparam int DcOffset = 1 << (PixelWidth - 1);

    pack_state_t                  state_q, state_d;
    logic signed [DataWidth-1:0]  even_q, even_d;
    logic                         even_sof_q, even_sof_d;
    logic signed [DataWidth-1:0]  last_odd_q, last_odd_d;
    logic                         row_first_q, row_first_d;

    logic                         load;
    logic [2*DataWidth-1:0]       pair_data;
    logic                         pair_sof;
    logic                         pair_eol;

    logic                         accept;
    logic signed [DataWidth-1:0]  conv;
    logic signed [DataWidth-1:0]  pad;

    assign s_ready_o = !m_valid_o || m_ready_i;
    assign accept    = s_valid_i && s_ready_o;
    assign conv      = DataWidth'(level_shift(int'(s_data_i), DcOffset, InShift));
    // A 1-pixel row (including one opened by sof) mirrors onto itself.
    assign pad       = (row_first_q || s_sof_i) ? conv : last_odd_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        even_d      = even_q;
        even_sof_d  = even_sof_q;
        last_odd_d  = last_odd_q;
        row_first_d = row_first_q;
        load        = 1'b0;
        pair_data   = '0;
        pair_sof    = 1'b0;
        pair_eol    = 1'b0;

        if (accept) begin
            // sof while an even is held is a resync: drop it and start afresh.
            if (state_q == EVEN || s_sof_i) begin
                if (s_eol_i) begin
                    load        = 1'b1;
                    pair_data   = {pad, conv};
                    pair_sof    = s_sof_i;
                    pair_eol    = 1'b1;
                    state_d     = EVEN;
                    row_first_d = 1'b1;
                end else begin
                    even_d      = conv;
                    even_sof_d  = s_sof_i;
                    state_d     = ODD;
                end
            end else begin
                load        = 1'b1;
                pair_data   = {conv, even_q};
                pair_sof    = even_sof_q;
                pair_eol    = s_eol_i;
                last_odd_d  = conv;
                row_first_d = s_eol_i;
                state_d     = EVEN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q     <= EVEN;
            even_q      <= '0;
            even_sof_q  <= 1'b0;
            last_odd_q  <= '0;
            row_first_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            even_q      <= even_d;
            even_sof_q  <= even_sof_d;
            last_odd_q  <= last_odd_d;
            row_first_q <= row_first_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_valid_o <= 1'b0;
            m_sof_o   <= 1'b0;
            m_eol_o   <= 1'b0;
            m_data_o  <= '0;
        end else if (load) begin
            m_valid_o <= 1'b1;
            m_sof_o   <= pair_sof;
            m_eol_o   <= pair_eol;
            m_data_o  <= pair_data;
        end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_pair_packer.sv
// Self-checking bench for pixel_pair_packer: directed rows plus randomized
// frames under random valid/ready, against a row-level reference model.
module tb_pixel_pair_packer;

    typedef struct {
        logic [31:0] data;
        logic        sof;
        logic        eol;
    } beat_t;

    typedef struct {
        int val;
        bit sof;
    } samp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        s_ready_o;
    logic        s_valid_i;
    logic        s_sof_i;
    logic        s_eol_i;
    logic [7:0]  s_data_i;
    logic        m_ready_i;
    logic        m_valid_o;
    logic        m_sof_o;
    logic        m_eol_o;
    logic [31:0] m_data_o;

    int vectors = 0;
    int errors  = 0;

    beat_t got_q[$];
    beat_t exp_q[$];
    samp_t row_q[$];

    pixel_pair_packer #(.PixelWidth(8), .DataWidth(16), .InShift(4)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .s_ready_o (s_ready_o),
        .s_valid_i (s_valid_i),
        .s_sof_i   (s_sof_i),
        .s_eol_i   (s_eol_i),
        .s_data_i  (s_data_i),
        .m_ready_i (m_ready_i),
        .m_valid_o (m_valid_o),
        .m_sof_o   (m_sof_o),
        .m_eol_o   (m_eol_o),
        .m_data_o  (m_data_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int conv(input int p);
        return (p - 128) * 16;
    endfunction

    function automatic logic [31:0] pack(input int odd, input int even);
        return {16'(odd), 16'(even)};
    endfunction

    // Row-level model: pairs are formed from the row's samples in order; an
    // odd tail is mirrored onto the preceding odd (or itself for a 1-pixel row).
    function automatic void model_push(input int p, input bit sof, input bit eol);
        int n;
        int pad;
        if (sof) row_q.delete();
        row_q.push_back('{val: conv(p), sof: sof});
        n = row_q.size();
        if (n % 2 == 0) begin
            exp_q.push_back('{data: pack(row_q[n-1].val, row_q[n-2].val),
                              sof: row_q[n-2].sof, eol: eol});
        end else if (eol) begin
            pad = (n == 1) ? row_q[0].val : row_q[n-2].val;
            exp_q.push_back('{data: pack(pad, row_q[n-1].val),
                              sof: row_q[n-1].sof, eol: 1'b1});
        end
        if (eol) row_q.delete();
    endfunction

    task automatic clear_queues();
        got_q.delete();
        exp_q.delete();
        row_q.delete();
    endtask

    // One clock: drive inputs after the falling edge, then observe what the
    // coming rising edge will transfer.
    task automatic step(input bit v, input bit sof, input bit eol,
                        input logic [7:0] d, input bit rdy, output bit acc);
        @(negedge clk_i);
        s_valid_i = v;
        s_sof_i   = sof;
        s_eol_i   = eol;
        s_data_i  = d;
        m_ready_i = rdy;
        #1;
        if (m_valid_o && m_ready_i)
            got_q.push_back('{data: m_data_o, sof: m_sof_o, eol: m_eol_o});
        acc = v && s_ready_o;
        if (acc) model_push(int'(d), sof, eol);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, acc);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i     = 1'b1;
        s_valid_i = 1'b0;
        m_ready_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        clear_queues();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (m_valid_o !== 1'b0 || m_sof_o !== 1'b0 || m_eol_o !== 1'b0 || m_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b sof=%b eol=%b data=%h, want 0 0 0 00000000",
                     m_valid_o, m_sof_o, m_eol_o, m_data_o);
        end
        vectors++;
        if (s_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", s_ready_o);
        end
    endtask

    task automatic test_first_row();
        bit acc;
        clear_queues();
        step(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, acc);
        step(1'b1, 1'b0, 1'b1, 8'd255, 1'b1, acc);
        vectors++;
        if (m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL first_row_early: valid=%b before second pixel transfers, want 0", m_valid_o);
        end
        idle(1);
        vectors++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL first_row_latency: got %0d beats one cycle after eol pixel, want 1", got_q.size());
        end else begin
            vectors++;
            if (got_q[0].data !== 32'h07F0F800 || got_q[0].sof !== 1'b1 || got_q[0].eol !== 1'b1) begin
                errors++;
                $display("FAIL first_row_beat: got %h sof=%b eol=%b want 07f0f800 sof=1 eol=1",
                         got_q[0].data, got_q[0].sof, got_q[0].eol);
            end
        end
        idle(1);
    endtask

    task automatic test_odd_row();
        bit acc;
        beat_t want[$];
        clear_queues();
        want.push_back('{data: 32'h00100000, sof: 1'b1, eol: 1'b0});
        want.push_back('{data: 32'h00100020, sof: 1'b0, eol: 1'b1});
        step(1'b1, 1'b1, 1'b0, 8'd128, 1'b1, acc);
        step(1'b1, 1'b0, 1'b0, 8'd129, 1'b1, acc);
        step(1'b1, 1'b0, 1'b1, 8'd130, 1'b1, acc);
        idle(2);
        vectors++;
        if (got_q.size() != want.size()) begin
            errors++;
            $display("FAIL odd_row_count: got %0d beats want %0d", got_q.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                vectors++;
                if (got_q[i] !== want[i]) begin
                    errors++;
                    $display("FAIL odd_row_beat%0d: got %h sof=%b eol=%b want %h sof=%b eol=%b", i,
                             got_q[i].data, got_q[i].sof, got_q[i].eol, want[i].data, want[i].sof, want[i].eol);
                end
            end
        end
    endtask

    task automatic test_one_pixel_row();
        bit acc;
        beat_t want[$];
        clear_queues();
        want.push_back('{data: 32'h04800480, sof: 1'b1, eol: 1'b1});
        want.push_back('{data: 32'h00000000, sof: 1'b0, eol: 1'b1});
        step(1'b1, 1'b1, 1'b1, 8'd200, 1'b1, acc);
        step(1'b1, 1'b0, 1'b0, 8'd128, 1'b1, acc);
        step(1'b1, 1'b0, 1'b1, 8'd128, 1'b1, acc);
        idle(2);
        vectors++;
        if (got_q.size() != want.size()) begin
            errors++;
            $display("FAIL one_pixel_count: got %0d beats want %0d", got_q.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                vectors++;
                if (got_q[i] !== want[i]) begin
                    errors++;
                    $display("FAIL one_pixel_beat%0d: got %h sof=%b eol=%b want %h sof=%b eol=%b", i,
                             got_q[i].data, got_q[i].sof, got_q[i].eol, want[i].data, want[i].sof, want[i].eol);
                end
            end
        end
    endtask

    task automatic test_resync();
        bit acc;
        clear_queues();
        step(1'b1, 1'b1, 1'b0, 8'd10, 1'b1, acc);
        step(1'b1, 1'b1, 1'b0, 8'd20, 1'b1, acc);
        step(1'b1, 1'b0, 1'b1, 8'd30, 1'b1, acc);
        idle(2);
        vectors++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL resync_count: got %0d beats want 1", got_q.size());
        end else begin
            vectors++;
            if (got_q[0].data !== 32'hF9E0F940 || got_q[0].sof !== 1'b1 || got_q[0].eol !== 1'b1) begin
                errors++;
                $display("FAIL resync_beat: got %h sof=%b eol=%b want f9e0f940 sof=1 eol=1",
                         got_q[0].data, got_q[0].sof, got_q[0].eol);
            end
        end
    endtask

    task automatic test_reset_mid_pair();
        bit acc;
        clear_queues();
        step(1'b1, 1'b1, 1'b0, 8'd50, 1'b1, acc);
        do_reset();
        vectors++;
        if (m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_valid: got %b want 0", m_valid_o);
        end
        step(1'b1, 1'b0, 1'b0, 8'd60, 1'b1, acc);
        step(1'b1, 1'b0, 1'b1, 8'd70, 1'b1, acc);
        idle(2);
        vectors++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL reset_mid_count: got %0d beats want 1", got_q.size());
        end else begin
            vectors++;
            if (got_q[0].data !== 32'hFC60FBC0 || got_q[0].sof !== 1'b0 || got_q[0].eol !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_beat: got %h sof=%b eol=%b want fc60fbc0 sof=0 eol=1",
                         got_q[0].data, got_q[0].sof, got_q[0].eol);
            end
        end
    endtask

    task automatic test_backpressure();
        bit          acc;
        logic [7:0]  pix[8];
        logic [31:0] held;
        int          idx;
        int          guard;
        clear_queues();
        foreach (pix[i]) pix[i] = 8'($urandom_range(0, 255));
        idx = 0;
        guard = 0;
        while (idx < 4 && guard < 50) begin
            step(1'b1, idx == 0, 1'b0, pix[idx], 1'b1, acc);
            if (acc) idx++;
            guard++;
        end
        held = m_data_o;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b0, idx == 7, pix[idx], 1'b0, acc);
            if (c == 0) held = m_data_o;
            if (acc) idx++;
            vectors++;
            if (s_ready_o !== 1'b0 || m_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL stall_ready c%0d: got s_ready=%b m_valid=%b want 0 1", c, s_ready_o, m_valid_o);
            end
            vectors++;
            if (m_data_o !== held) begin
                errors++;
                $display("FAIL stall_data c%0d: got %h want %h", c, m_data_o, held);
            end
        end
        guard = 0;
        while (idx < 8 && guard < 50) begin
            step(1'b1, 1'b0, idx == 7, pix[idx], 1'b1, acc);
            if (acc) idx++;
            guard++;
        end
        idle(3);
        vectors++;
        if (got_q.size() != 4 || exp_q.size() != 4) begin
            errors++;
            $display("FAIL stall_count: got %0d beats want 4 (model %0d)", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL stall_beat%0d: got %h sof=%b eol=%b want %h sof=%b eol=%b", i,
                             got_q[i].data, got_q[i].sof, got_q[i].eol, exp_q[i].data, exp_q[i].sof, exp_q[i].eol);
                end
            end
        end
    endtask

    task automatic test_random_frames();
        bit         acc;
        bit         sof;
        bit         eol;
        logic [7:0] d;
        int         len;
        int         guard;
        clear_queues();
        for (int f = 0; f < 8; f++) begin
            for (int r = 0; r < 4; r++) begin
                len = $urandom_range(1, 7);
                for (int i = 0; i < len; i++) begin
                    sof = (r == 0 && i == 0) || (i > 0 && $urandom_range(0, 19) == 0);
                    eol = (i == len - 1);
                    d   = 8'($urandom_range(0, 255));
                    guard = 0;
                    do begin
                        step($urandom_range(0, 3) != 0, sof, eol, d, $urandom_range(0, 3) != 0, acc);
                        guard++;
                    end while (!acc && guard < 200);
                    if (!acc) begin
                        vectors++;
                        errors++;
                        $display("FAIL random_timeout: pixel not accepted within 200 cycles");
                    end
                end
            end
        end
        idle(4);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d beats want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_beat%0d: got %h sof=%b eol=%b want %h sof=%b eol=%b", i,
                         got_q[i].data, got_q[i].sof, got_q[i].eol, exp_q[i].data, exp_q[i].sof, exp_q[i].eol);
            end
        end
    endtask

    initial begin
        rst_i     = 1'b1;
        s_valid_i = 1'b0;
        s_sof_i   = 1'b0;
        s_eol_i   = 1'b0;
        s_data_i  = 8'h00;
        m_ready_i = 1'b1;
        test_reset();
        test_first_row();
        test_odd_row();
        test_one_pixel_row();
        test_resync();
        test_reset_mid_pair();
        test_backpressure();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pixel_pair_packer.md
Name: pixel_pair_packer

Overview:
- Front-end stage directly upstream of the 2-D 9/7 DWT core.
- Takes a raster stream of unsigned pixels, one per beat, and applies the JPEG2000 DC level shift and a fixed-point scale.
- Packs consecutive samples into {odd, even} pairs on the same sof/eol ready/valid stream the DWT consumes.
- Odd-length rows are completed with a symmetric-extension pad, so the DWT always receives whole pairs.

Parameters:
- PixelWidth, 8, bit depth of unsigned input pixels.
- DataWidth, 16, width of each signed output sample; matches the DWT DataWidth.
- InShift, 4, left shift applied after the level shift. Output value in DWT fixed point = (pix - 2^(PixelWidth-1)) * 2^InShift. Elaboration error unless PixelWidth+InShift <= DataWidth.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- s_ready_o  out  1  upstream ready
- s_valid_i  in  1  upstream valid
- s_sof_i  in  1  first pixel of frame
- s_eol_i  in  1  last pixel of row
- s_data_i  in  PixelWidth  unsigned pixel
- m_ready_i  in  1  downstream ready
- m_valid_o  out  1  pair valid
- m_sof_o  out  1  pair holds first pixel of frame
- m_eol_o  out  1  pair holds last pixel of row
- m_data_o  out  2*DataWidth  {odd, even}, each signed DataWidth

Behaviour:
- Clock and reset: single clock clk_i. rst_i is synchronous and active-high.
- Reset values:
  - m_valid_o=0, m_sof_o=0, m_eol_o=0, m_data_o=0.
  - State EVEN, held-even register cleared, last_odd register cleared, row_first=1.
- Transfer rule: a beat transfers when valid&&ready, on either side.
- Input readiness: s_ready_o = !m_valid_o || m_ready_i, in both states. It is combinational from m_ready_i.
- Conversion: conv(p) = sign-extend((p - 2^(PixelWidth-1)) << InShift) to DataWidth. It cannot overflow.
- State EVEN, on an accepted beat:
  - eol=0: store conv(pixel) as even, store sof, go to ODD. No output.
  - eol=1 (odd-length row): emit pair {pad, conv(pixel)} with eol=1 and sof=s_sof_i. Stay in EVEN. Set row_first=1.
  - pad value: last_odd, or conv(pixel) itself when row_first=1 (row length 1).
- State ODD, on an accepted beat:
  - sof=0: emit {conv(pixel), held even} with m_sof_o = held sof and m_eol_o = s_eol_i.
  - Register conv(pixel) into last_odd. row_first becomes s_eol_i. Go to EVEN.
  - sof=1 (resync): discard the held even. Treat this pixel as a new even sample with sof=1 (EVEN rules apply, including the eol=1 case). No output for the discarded sample.
- Output register:
  - Loading a pair sets m_valid_o=1.
  - m_valid_o clears on m_ready_i when no new pair is loaded that cycle.
  - Data and flags stay stable while m_valid_o && !m_ready_i.
- Latency: pair appears on m_* the cycle after its second (or padding) input sample is accepted.
- Throughput: one pixel per cycle, one pair per two cycles without backpressure.
- s_eol_i on the first sample after sof is legal (1-pixel row).
- Reset mid-pair: the held even is discarded and any pending output is dropped. The first accepted pixel after reset is an even sample.

Decomposition:
- dwt97_pkg holds:
  - enum pack_state_t {EVEN, ODD};
  - function level_shift(pix) returning the conv() value;
  - localparam for the DC offset.
- No sub-module is required. The output register is inline, because the DWT input stage already decouples timing.

Test Plan:
- Row [0 sof, 255 eol] with m_ready_i=1 -> one beat m_data_o={0x07F0,0xF800}, sof=1, eol=1. Appears one cycle after 255 is accepted.
- Odd row [128 sof, 129, 130 eol] -> beat1 {0x0010,0x0000} sof=1 eol=0; beat2 {0x0010,0x0020} sof=0 eol=1 (pad = x[1]).
- One-pixel row [200 sof eol] -> {0x0480,0x0480}, sof=1, eol=1. A following 2-pixel row [128,128 eol] -> {0x0000,0x0000} with row_first pad logic unaffected.
- Backpressure: m_ready_i=0 for 5 cycles while a pair is held, upstream valid continuous:
  - s_ready_o=0 for those cycles;
  - m_data_o stable;
  - no sample lost or duplicated once m_ready_i returns.
- Resync: [10 sof, 20 sof, 30 eol] -> single beat {0xF9E0,0xF940}, sof=1, eol=1. Pixel 10 is dropped.
- Reset mid-pair: accept pixel 50, assert rst_i one cycle:
  - m_valid_o=0 next cycle;
  - the next pixel pair [60,70 eol] yields {0xFC60,0xFBC0}.
